// File: rtl/fir_sm_fifo.sv
// rtl/fir_sm_fifo.sv - output-side AXI-Stream FWFT FIFO behind the FIR sm_* port
// Optional frame-length checker enabled by FIR_SM_FIFO_FRAME_CHECK_EN.
module fir_sm_fifo #(
    parameter int pDATA_WIDTH = 32,
    parameter int pDEPTH_LOG2 = 4,
    parameter int pAFULL      = 12
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst,
    input  logic                   s_tvalid,
    input  logic [pDATA_WIDTH-1:0] s_tdata,
    input  logic                   s_tlast,
    output logic                   s_tready,
    output logic                   m_tvalid,
    output logic [pDATA_WIDTH-1:0] m_tdata,
    output logic                   m_tlast,
    input  logic                   m_tready,
    output logic [pDEPTH_LOG2:0]   level,
    output logic                   almost_full,
    output logic                   frame_done
`ifdef FIR_SM_FIFO_FRAME_CHECK_EN
    ,
    input  logic [31:0]            cfg_length,
    output logic                   len_err
`endif
);

    localparam int DEPTH = 1 << pDEPTH_LOG2;
    localparam int LW    = pDEPTH_LOG2 + 1;

    typedef logic [pDATA_WIDTH:0] word_t;

    word_t                   r_mem [DEPTH];
    logic [pDEPTH_LOG2-1:0]  r_wr_ptr;
    logic [pDEPTH_LOG2-1:0]  r_rd_ptr;
    logic [LW-1:0]           r_level;
    logic                    r_m_tvalid;
    logic [pDATA_WIDTH-1:0]  r_m_tdata;
    logic                    r_m_tlast;
    logic                    r_almost_full;
    logic                    r_frame_done;

    logic                    w_push;
    logic                    w_pop;
    logic [LW-1:0]           w_level_after_pop;
    logic [LW-1:0]           w_level_next;
    logic [pDEPTH_LOG2-1:0]  w_rd_ptr_next;
    word_t                   w_head;

    assign s_tready    = (r_level != LW'(DEPTH));
    assign m_tvalid    = r_m_tvalid;
    assign m_tdata     = r_m_tdata;
    assign m_tlast     = r_m_tlast;
    assign level       = r_level;
    assign almost_full = r_almost_full;
    assign frame_done  = r_frame_done;

    assign w_push            = s_tvalid & s_tready;
    assign w_pop             = r_m_tvalid & m_tready;
    assign w_level_after_pop = r_level - {{(LW-1){1'b0}}, w_pop};
    assign w_level_next      = w_level_after_pop + {{(LW-1){1'b0}}, w_push};
    assign w_rd_ptr_next     = r_rd_ptr + {{(pDEPTH_LOG2-1){1'b0}}, w_pop};

    // The output register mirrors the head entry; an incoming word becomes the
    // head only when the array would otherwise be empty after this edge.
    assign w_head = (w_push && (w_level_after_pop == '0)) ? {s_tlast, s_tdata}
                                                          : r_mem[w_rd_ptr_next];

    always_ff @(posedge axis_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {s_tlast, s_tdata};
        end
    end

    always_ff @(posedge axis_clk or posedge axis_rst) begin
        if (axis_rst) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_level       <= '0;
            r_m_tvalid    <= 1'b0;
            r_m_tdata     <= '0;
            r_m_tlast     <= 1'b0;
            r_almost_full <= 1'b0;
            r_frame_done  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            r_rd_ptr      <= w_rd_ptr_next;
            r_level       <= w_level_next;
            r_almost_full <= (w_level_next >= LW'(pAFULL));
            r_frame_done  <= w_pop & r_m_tlast;
            if (w_level_next != '0) begin
                r_m_tvalid <= 1'b1;
                r_m_tlast  <= w_head[pDATA_WIDTH];
                r_m_tdata  <= w_head[pDATA_WIDTH-1:0];
            end else begin
                r_m_tvalid <= 1'b0;
                r_m_tlast  <= 1'b0;
            end
        end
    end

`ifdef FIR_SM_FIFO_FRAME_CHECK_EN
    logic [31:0] r_beat_cnt;
    logic        r_len_err;
    logic [31:0] w_cnt_inc;

    assign w_cnt_inc = r_beat_cnt + 32'd1;
    assign len_err   = r_len_err;

    // A zero cfg_length leaves the counter running but never flags an error.
    always_ff @(posedge axis_clk or posedge axis_rst) begin
        if (axis_rst) begin
            r_beat_cnt <= '0;
            r_len_err  <= 1'b0;
        end else if (w_push) begin
            r_beat_cnt <= s_tlast ? 32'd0 : w_cnt_inc;
            if (cfg_length != 32'd0) begin
                if (s_tlast && (w_cnt_inc != cfg_length)) begin
                    r_len_err <= 1'b1;
                end
                if (!s_tlast && (w_cnt_inc == cfg_length)) begin
                    r_len_err <= 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_fir_sm_fifo.sv
// tb/tb_fir_sm_fifo.sv - randomized self-checking bench for fir_sm_fifo
module tb_fir_sm_fifo;

    localparam int DW    = 32;
    localparam int DL    = 4;
    localparam int DEPTH = 16;
    localparam int AF    = 12;

    typedef logic [DL:0] lvl_t;
    typedef logic [DW:0] word_t;

    logic          axis_clk = 1'b0;
    logic          axis_rst = 1'b1;
    logic          s_tvalid = 1'b0;
    logic [DW-1:0] s_tdata  = '0;
    logic          s_tlast  = 1'b0;
    logic          s_tready;
    logic          m_tvalid;
    logic [DW-1:0] m_tdata;
    logic          m_tlast;
    logic          m_tready = 1'b0;
    logic [DL:0]   level;
    logic          almost_full;
    logic          frame_done;
`ifdef FIR_SM_FIFO_FRAME_CHECK_EN
    logic [31:0]   cfg_length = '0;
    logic          len_err;
`endif

    fir_sm_fifo #(.pDATA_WIDTH(DW), .pDEPTH_LOG2(DL), .pAFULL(AF)) dut (
        .axis_clk    (axis_clk),
        .axis_rst    (axis_rst),
        .s_tvalid    (s_tvalid),
        .s_tdata     (s_tdata),
        .s_tlast     (s_tlast),
        .s_tready    (s_tready),
        .m_tvalid    (m_tvalid),
        .m_tdata     (m_tdata),
        .m_tlast     (m_tlast),
        .m_tready    (m_tready),
        .level       (level),
        .almost_full (almost_full),
        .frame_done  (frame_done)
`ifdef FIR_SM_FIFO_FRAME_CHECK_EN
        ,
        .cfg_length  (cfg_length),
        .len_err     (len_err)
`endif
    );

    always #5 axis_clk = ~axis_clk;

    int    pass_cnt  = 0;
    int    total_cnt = 0;
    word_t q[$];
    bit    exp_fd;

    // Reference model: the FIFO is a queue of {tlast,data}; one call = one clock.
    task automatic tick(input logic v, input logic [DW-1:0] d, input logic l, input logic r);
        bit    push;
        bit    pop;
        word_t h;
        s_tvalid = v;
        s_tdata  = d;
        s_tlast  = l;
        m_tready = r;
        push = v && (q.size() < DEPTH);
        pop  = r && (q.size() > 0);
        h    = (q.size() > 0) ? q[0] : '0;
        @(posedge axis_clk);
        exp_fd = pop && h[DW];
        if (pop) void'(q.pop_front());
        if (push) q.push_back({l, d});
        @(negedge axis_clk);
    endtask

    task automatic do_reset();
        axis_rst = 1'b1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        m_tready = 1'b0;
        repeat (2) @(negedge axis_clk);
        axis_rst = 1'b0;
        q.delete();
        exp_fd = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total_cnt += 7;
        if (level !== 5'd0) $display("FAIL reset_level got=%0d exp=0", level); else pass_cnt++;
        if (m_tvalid !== 1'b0) $display("FAIL reset_m_tvalid got=%b exp=0", m_tvalid); else pass_cnt++;
        if (m_tdata !== 32'd0) $display("FAIL reset_m_tdata got=%h exp=0", m_tdata); else pass_cnt++;
        if (m_tlast !== 1'b0) $display("FAIL reset_m_tlast got=%b exp=0", m_tlast); else pass_cnt++;
        if (frame_done !== 1'b0) $display("FAIL reset_frame_done got=%b exp=0", frame_done); else pass_cnt++;
        if (almost_full !== 1'b0) $display("FAIL reset_almost_full got=%b exp=0", almost_full); else pass_cnt++;
        if (s_tready !== 1'b1) $display("FAIL reset_s_tready got=%b exp=1", s_tready); else pass_cnt++;
    endtask

    task automatic test_fill();
        for (int i = 1; i <= DEPTH; i++) begin
            tick(1'b1, DW'(i), (i == DEPTH), 1'b0);
            total_cnt += 4;
            if (level !== lvl_t'(q.size())) $display("FAIL fill_level i=%0d got=%0d exp=%0d", i, level, q.size()); else pass_cnt++;
            if (almost_full !== (i >= AF)) $display("FAIL fill_almost_full i=%0d got=%b exp=%b", i, almost_full, (i >= AF)); else pass_cnt++;
            if (s_tready !== (i != DEPTH)) $display("FAIL fill_s_tready i=%0d got=%b exp=%b", i, s_tready, (i != DEPTH)); else pass_cnt++;
            if (m_tdata !== 32'd1 || m_tvalid !== 1'b1) $display("FAIL fill_hold i=%0d got=%h/%b exp=1/1", i, m_tdata, m_tvalid); else pass_cnt++;
        end
        tick(1'b1, 32'hBAD0_0000, 1'b0, 1'b0);
        total_cnt++;
        if (level !== 5'd16) $display("FAIL full_no_overwrite got=%0d exp=16", level); else pass_cnt++;
    endtask

    task automatic test_drain();
        for (int i = 0; i < DEPTH; i++) begin
            total_cnt++;
            if (m_tvalid !== 1'b1 || {m_tlast, m_tdata} !== {(i == DEPTH - 1), DW'(i + 1)})
                $display("FAIL drain_word i=%0d got=%b/%h exp=%b/%h", i, m_tlast, m_tdata, (i == DEPTH - 1), i + 1);
            else pass_cnt++;
            tick((i == 0), 32'hDEAD_BEEF, 1'b0, 1'b1);
            total_cnt++;
            if (frame_done !== exp_fd) $display("FAIL drain_frame_done i=%0d got=%b exp=%b", i, frame_done, exp_fd); else pass_cnt++;
            if (i == 0) begin
                total_cnt += 2;
                if (s_tready !== 1'b1) $display("FAIL drain_s_tready got=%b exp=1", s_tready); else pass_cnt++;
                if (level !== 5'd15) $display("FAIL drain_first_level got=%0d exp=15", level); else pass_cnt++;
            end
        end
        total_cnt += 2;
        if (level !== 5'd0) $display("FAIL drain_level got=%0d exp=0", level); else pass_cnt++;
        if (m_tvalid !== 1'b0) $display("FAIL drain_m_tvalid got=%b exp=0", m_tvalid); else pass_cnt++;
    endtask

    task automatic test_stream();
        logic [DW-1:0] words [500];
        int sent = 0;
        int recv = 0;
        int fd_cnt = 0;
        int last_cnt = 0;
        int cyc = 0;
        int errs = 0;
        logic r;
        for (int k = 0; k < 500; k++) words[k] = $urandom;
        while (recv < 500 && cyc < 20000) begin
            r = ($urandom_range(0, 2) != 0);
            if (s_tready !== (q.size() != DEPTH) || m_tvalid !== (q.size() > 0)) errs++;
            if (q.size() > 0 && r) begin
                if ({m_tlast, m_tdata} !== {(recv == 499), words[recv]}) begin
                    errs++;
                    if (errs < 5) $display("FAIL stream_word n=%0d got=%b/%h exp=%b/%h", recv, m_tlast, m_tdata, (recv == 499), words[recv]);
                end
                if (m_tlast === 1'b1) last_cnt++;
                recv++;
            end
            if (sent < 500 && q.size() < DEPTH) begin
                tick(1'b1, words[sent], (sent == 499), r);
                sent++;
            end else begin
                tick(sent < 500, (sent < 500) ? words[sent] : '0, (sent == 499), r);
            end
            if (frame_done === 1'b1) fd_cnt++;
            if (frame_done !== exp_fd) errs++;
            cyc++;
        end
        tick(1'b0, '0, 1'b0, 1'b0);
        if (frame_done === 1'b1) fd_cnt++;
        total_cnt += 4;
        if (errs != 0) $display("FAIL stream_cycle_checks got=%0d errors exp=0", errs); else pass_cnt++;
        if (recv != 500) $display("FAIL stream_count got=%0d exp=500", recv); else pass_cnt++;
        if (last_cnt != 1) $display("FAIL stream_tlast_count got=%0d exp=1", last_cnt); else pass_cnt++;
        if (fd_cnt != 1) $display("FAIL stream_frame_done_count got=%0d exp=1", fd_cnt); else pass_cnt++;
    endtask

    task automatic test_concurrent();
        word_t h;
        for (int i = 0; i < 5; i++) tick(1'b1, $urandom, 1'b0, 1'b0);
        total_cnt++;
        if (level !== 5'd5) $display("FAIL conc_fill_level got=%0d exp=5", level); else pass_cnt++;
        for (int i = 0; i < 20; i++) begin
            h = q[0];
            total_cnt++;
            if ({m_tlast, m_tdata} !== h) $display("FAIL conc_word i=%0d got=%h exp=%h", i, {m_tlast, m_tdata}, h); else pass_cnt++;
            tick(1'b1, $urandom, 1'b0, 1'b1);
            total_cnt++;
            if (level !== 5'd5) $display("FAIL conc_level i=%0d got=%0d exp=5", i, level); else pass_cnt++;
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 7; i++) tick(1'b1, $urandom, 1'b0, 1'b0);
        total_cnt++;
        if (level !== 5'd7) $display("FAIL areset_pre_level got=%0d exp=7", level); else pass_cnt++;
        #2 axis_rst = 1'b1;
        #1;
        total_cnt += 2;
        if (level !== 5'd0) $display("FAIL areset_level got=%0d exp=0", level); else pass_cnt++;
        if (m_tvalid !== 1'b0) $display("FAIL areset_m_tvalid got=%b exp=0", m_tvalid); else pass_cnt++;
        @(negedge axis_clk);
        axis_rst = 1'b0;
        q.delete();
        exp_fd = 1'b0;
        tick(1'b1, 32'hA5A5_0001, 1'b0, 1'b0);
        tick(1'b1, 32'hA5A5_0002, 1'b1, 1'b0);
        total_cnt += 2;
        if (m_tvalid !== 1'b1 || m_tdata !== 32'hA5A5_0001) $display("FAIL areset_first got=%b/%h exp=1/a5a50001", m_tvalid, m_tdata); else pass_cnt++;
        if (level !== 5'd2) $display("FAIL areset_level2 got=%0d exp=2", level); else pass_cnt++;
        tick(1'b0, '0, 1'b0, 1'b1);
        total_cnt++;
        if (m_tdata !== 32'hA5A5_0002 || m_tlast !== 1'b1) $display("FAIL areset_second got=%h/%b exp=a5a50002/1", m_tdata, m_tlast); else pass_cnt++;
        tick(1'b0, '0, 1'b0, 1'b1);
        total_cnt++;
        if (frame_done !== 1'b1) $display("FAIL areset_frame_done got=%b exp=1", frame_done); else pass_cnt++;
    endtask

`ifdef FIR_SM_FIFO_FRAME_CHECK_EN
    task automatic test_frame_check();
        do_reset();
        cfg_length = 32'd500;
        for (int k = 1; k <= 499; k++) tick(1'b1, DW'(k), (k == 499), 1'b1);
        total_cnt++;
        if (len_err !== 1'b1) $display("FAIL len_err_short got=%b exp=1", len_err); else pass_cnt++;
        repeat (3) tick(1'b0, '0, 1'b0, 1'b1);
        total_cnt++;
        if (len_err !== 1'b1) $display("FAIL len_err_sticky got=%b exp=1", len_err); else pass_cnt++;
        do_reset();
        total_cnt++;
        if (len_err !== 1'b0) $display("FAIL len_err_reset got=%b exp=0", len_err); else pass_cnt++;
        for (int k = 1; k <= 500; k++) tick(1'b1, DW'(k), (k == 500), 1'b1);
        total_cnt++;
        if (len_err !== 1'b0) $display("FAIL len_err_exact got=%b exp=0", len_err); else pass_cnt++;
    endtask
`endif

    initial begin
        exp_fd = 1'b0;
        test_reset();
        test_fill();
        test_drain();
        test_stream();
        test_concurrent();
        test_async_reset();
`ifdef FIR_SM_FIFO_FRAME_CHECK_EN
        test_frame_check();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
